rect_cmd_sequencer: RTL and testbench

RECT_CMD_SEQUENCER -- requirements
Module: rect_cmd_sequencer

---
 rtl/rect_cmd_sequencer_if.sv | 32 +++
 rtl/rect_cmd_sequencer.sv | 128 ++++++++++++
 tb/tb_rect_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_cmd_sequencer_if.sv
// Command-in / drawer-out bus of the rectangle command sequencer.
// The sequencer takes the slave view; the upstream/drawer side takes the master view.
interface rect_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_x;
   logic [6:0]  cmd_y;
   logic [7:0]  cmd_w;
   logic [6:0]  cmd_h;
   logic [23:0] cmd_color;
   logic        drw_start;
   logic [14:0] drw_base_addr;
   logic [7:0]  drw_width;
   logic [6:0]  drw_height;
   logic [23:0] drw_color;
   logic        drw_done;
   logic        busy;
   logic [2:0]  queue_count;
   logic        dropped;

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, drw_done,
      output cmd_ready, drw_start, drw_base_addr, drw_width, drw_height, drw_color,
             busy, queue_count, dropped
   );

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, drw_done,
      input  cmd_ready, drw_start, drw_base_addr, drw_width, drw_height, drw_color,
             busy, queue_count, dropped
   );
endinterface

// File: rtl/rect_cmd_sequencer.sv
// Queues rectangle fill commands, clips them to the virtual frame and hands
// them one at a time to a downstream drawer, waiting for its done edge.
module rect_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int VW    = 160,
   parameter int VH    = 120
) (
   input logic clk,
   input logic rst,
   rect_cmd_sequencer_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0]  VW9  = 9'(VW);
   localparam logic [8:0]  VH9  = 9'(VH);
   localparam logic [14:0] VH15 = 15'(VH);

   typedef struct packed {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [7:0]  w;
      logic [6:0]  h;
      logic [23:0] color;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, POP, CLIP, ISSUE, WAIT} state_t;

   state_t        state, next;
   cmd_t          mem [DEPTH];
   cmd_t          cur;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [2:0]    count;
   logic          push, pop, start, drop_pulse;
   logic          done_q, done_rise;
   logic          drop;
   logic [8:0]    rem_w, rem_h;
   logic [7:0]    clip_w;
   logic [6:0]    clip_h;

   assign bus.cmd_ready   = ({1'b0, count} < 4'(DEPTH));
   assign push            = bus.cmd_valid && bus.cmd_ready;
   assign bus.queue_count = count;
   assign bus.busy        = (state != IDLE) || (count != 3'd0);
   assign bus.drw_start   = start;
   assign bus.dropped     = drop_pulse;
   assign done_rise       = bus.drw_done && !done_q;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w, h: bus.cmd_h,
                          color: bus.cmd_color};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Remaining room is 9 bits wide so x/y beyond the frame cannot wrap.
   always_comb begin
      rem_w  = VW9 - {1'b0, cur.x};
      rem_h  = VH9 - {2'b0, cur.y};
      drop   = ({1'b0, cur.x} >= VW9) || ({2'b0, cur.y} >= VH9) ||
               (cur.w == 8'd0) || (cur.h == 7'd0);
      clip_w = ({1'b0, cur.w} < rem_w) ? cur.w : rem_w[7:0];
      clip_h = ({2'b0, cur.h} < rem_h) ? cur.h : rem_h[6:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         done_q            <= 1'b1;
         cur               <= '0;
         bus.drw_base_addr <= '0;
         bus.drw_width     <= '0;
         bus.drw_height    <= '0;
         bus.drw_color     <= '0;
      end else begin
         state  <= next;
         done_q <= bus.drw_done;
         if (pop) cur <= mem[rd_ptr];
         if (state == CLIP && !drop) begin
            bus.drw_base_addr <= 15'(cur.x) * VH15 + 15'(cur.y);
            bus.drw_width     <= clip_w;
            bus.drw_height    <= clip_h;
            bus.drw_color     <= cur.color;
         end
      end
   end

   always_comb begin
      next       = state;
      pop        = 1'b0;
      start      = 1'b0;
      drop_pulse = 1'b0;
      case (state)
         IDLE:  if (count != 3'd0) next = POP;
         POP: begin
            pop  = 1'b1;
            next = CLIP;
         end
         CLIP: begin
            if (drop) begin
               drop_pulse = 1'b1;
               next       = IDLE;
            end else begin
               next = ISSUE;
            end
         end
         ISSUE: begin
            start = 1'b1;
            next  = WAIT;
         end
         WAIT:    if (done_rise) next = IDLE;
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// Directed bench for rect_cmd_sequencer: latency, clipping, drops, full queue,
// sticky done and mid-operation reset.
module tb_rect_cmd_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   n_drop = 0;
   logic [23:0] iss_col[$];

   rect_cmd_sequencer_if bus();

   rect_cmd_sequencer #(.DEPTH(4), .VW(160), .VH(120)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.drw_start) iss_col.push_back(bus.drw_color);
      if (bus.dropped) n_drop <= n_drop + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [60:0] outs();
      return {bus.cmd_ready, bus.drw_start, bus.dropped, bus.busy, bus.queue_count,
              bus.drw_base_addr, bus.drw_width, bus.drw_height, bus.drw_color};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                           input logic [6:0] h, input logic [23:0] c);
      bit ok = 1'b0;
      bus.cmd_x = x; bus.cmd_y = y; bus.cmd_w = w; bus.cmd_h = h; bus.cmd_color = c;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (bus.cmd_ready) ok = 1'b1;
         step();
      end
      bus.cmd_valid = 1'b0;
      if (!ok) begin
         $display("FAIL push_timeout color=%h never accepted", c);
         $fatal(1, "push timeout");
      end
   endtask

   task automatic wait_start(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (iss_col.size() >= target) ok = 1'b1;
         else step();
      end
   endtask

   task automatic pulse_done();
      bus.drw_done = 1'b1;
      step();
      bus.drw_done = 1'b0;
      step();
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (outs() !== {1'b1, 60'd0}) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=%h", outs(), {1'b1, 60'd0});
      end
      repeat (2) step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      push_cmd(8'd10, 7'd5, 8'd20, 7'd20, 24'hFFFFFF);
      for (int i = 1; i <= 2; i++) begin
         step();
         checks++;
         if (bus.drw_start !== 1'b0) begin
            errors++;
            $display("FAIL single_early_start cycle=%0d got=%b want=0", i, bus.drw_start);
         end
      end
      step();
      checks++;
      if (bus.drw_start !== 1'b1) begin
         errors++;
         $display("FAIL single_latency got=%b want=1", bus.drw_start);
      end
      checks++;
      if ({bus.drw_base_addr, bus.drw_width, bus.drw_height, bus.drw_color} !==
          {15'd1205, 8'd20, 7'd20, 24'hFFFFFF}) begin
         errors++;
         $display("FAIL single_fields got=%0d/%0d/%0d/%h want=1205/20/20/ffffff",
                  bus.drw_base_addr, bus.drw_width, bus.drw_height, bus.drw_color);
      end
      step();
      checks++;
      if ({bus.drw_start, bus.busy} !== 2'b01) begin
         errors++;
         $display("FAIL single_wait start/busy got=%b want=01", {bus.drw_start, bus.busy});
      end
      pulse_done();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_idle busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_clip();
      int s0 = iss_col.size();
      bit ok;
      push_cmd(8'd150, 7'd110, 8'd20, 7'd20, 24'h00FF00);
      wait_start(s0 + 1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL clip_start timeout issued=%0d want=%0d", iss_col.size(), s0 + 1);
      end
      checks++;
      if ({bus.drw_base_addr, bus.drw_width, bus.drw_height} !== {15'd18110, 8'd10, 7'd10}) begin
         errors++;
         $display("FAIL clip_fields got=%0d/%0d/%0d want=18110/10/10",
                  bus.drw_base_addr, bus.drw_width, bus.drw_height);
      end
      pulse_done();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL clip_idle busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_drop();
      int s0 = iss_col.size();
      int d0 = n_drop;
      push_cmd(8'd160, 7'd0, 8'd5, 7'd5, 24'h000001);
      push_cmd(8'd0, 7'd0, 8'd5, 7'd0, 24'h000002);
      repeat (12) step();
      checks++;
      if ((n_drop - d0) != 2 || iss_col.size() != s0) begin
         errors++;
         $display("FAIL drop_counts dropped=%0d starts=%0d want=2/0", n_drop - d0,
                  iss_col.size() - s0);
      end
      checks++;
      if ({bus.queue_count, bus.busy} !== 4'b0000) begin
         errors++;
         $display("FAIL drop_idle count/busy got=%b want=0000", {bus.queue_count, bus.busy});
      end
   endtask

   task automatic test_full_queue();
      int s0 = iss_col.size();
      bit ok;
      for (int i = 1; i <= 5; i++) push_cmd(8'(i), 7'(i), 8'd1, 7'd1, 24'(i));
      checks++;
      if ({bus.cmd_ready, bus.queue_count} !== {1'b0, 3'd4}) begin
         errors++;
         $display("FAIL full_state ready/count got=%b/%0d want=0/4", bus.cmd_ready,
                  bus.queue_count);
      end
      bus.cmd_x = 8'd6; bus.cmd_y = 7'd6; bus.cmd_w = 8'd1; bus.cmd_h = 7'd1;
      bus.cmd_color = 24'd6; bus.cmd_valid = 1'b1;
      repeat (4) step();
      checks++;
      if ({bus.cmd_ready, bus.queue_count} !== {1'b0, 3'd4} || iss_col.size() != s0 + 1) begin
         errors++;
         $display("FAIL full_holdoff ready/count/starts got=%b/%0d/%0d want=0/4/1",
                  bus.cmd_ready, bus.queue_count, iss_col.size() - s0);
      end
      pulse_done();
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.cmd_ready) ok = 1'b1;
         step();
      end
      bus.cmd_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_sixth_accept ready got=0 want=1");
      end
      for (int k = 2; k <= 6; k++) begin
         wait_start(s0 + k, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL full_drain_%0d issued=%0d want=%0d", k, iss_col.size() - s0, k);
         end
         pulse_done();
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (iss_col.size() <= s0 + k || iss_col[s0 + k] !== 24'(k + 1)) begin
            errors++;
            $display("FAIL full_order_%0d got=%h want=%h", k,
                     (iss_col.size() > s0 + k) ? iss_col[s0 + k] : 24'hx, 24'(k + 1));
         end
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL full_idle busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_sticky_done();
      int s0 = iss_col.size();
      bit ok;
      push_cmd(8'd1, 7'd1, 8'd2, 7'd2, 24'h0000AA);
      push_cmd(8'd2, 7'd2, 8'd2, 7'd2, 24'h0000BB);
      wait_start(s0 + 1, ok);
      bus.drw_done = 1'b1;
      wait_start(s0 + 2, ok);
      checks++;
      if (!ok || iss_col[s0 + 1] !== 24'h0000BB) begin
         errors++;
         $display("FAIL sticky_second_issue issued=%0d want=2", iss_col.size() - s0);
      end
      repeat (6) step();
      checks++;
      if (bus.busy !== 1'b1 || iss_col.size() != s0 + 2) begin
         errors++;
         $display("FAIL sticky_early_complete busy=%b starts=%0d want=1/2", bus.busy,
                  iss_col.size() - s0);
      end
      bus.drw_done = 1'b0;
      step();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL sticky_fall busy got=%b want=1", bus.busy);
      end
      bus.drw_done = 1'b1;
      step();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL sticky_rise busy got=%b want=0", bus.busy);
      end
      bus.drw_done = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int s0 = iss_col.size();
      bit ok;
      for (int i = 0; i < 3; i++) push_cmd(8'd3, 7'd3, 8'd4, 7'd4, 24'h10 + 24'(i));
      wait_start(s0 + 1, ok);
      checks++;
      if (!ok || bus.queue_count !== 3'd2) begin
         errors++;
         $display("FAIL rstmid_setup count got=%0d want=2", bus.queue_count);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (outs() !== {1'b1, 60'd0}) begin
         errors++;
         $display("FAIL rstmid_outputs got=%h want=%h", outs(), {1'b1, 60'd0});
      end
      #3 rst = 1'b1;
      repeat (12) step();
      checks++;
      if (iss_col.size() != s0 + 1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_quiet starts=%0d busy=%b want=1/0", iss_col.size() - s0,
                  bus.busy);
      end
      push_cmd(8'd0, 7'd0, 8'd1, 7'd1, 24'h000077);
      wait_start(s0 + 2, ok);
      checks++;
      if (!ok || iss_col[iss_col.size() - 1] !== 24'h000077) begin
         errors++;
         $display("FAIL rstmid_new_cmd issued=%0d want=2", iss_col.size() - s0);
      end
      pulse_done();
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0;
      bus.cmd_h = '0; bus.cmd_color = '0; bus.drw_done = 1'b0;
      test_reset();
      test_single();
      test_clip();
      test_drop();
      test_full_queue();
      test_sticky_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
